score_bcd_converter: RTL



---
 rtl/score_bcd_converter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential binary-to-BCD converter (shift-add-3, one bit
// per clock). It blanks leading zeros with 4'hF and saturates to all nines when
// the value overflows. The digit and ovf outputs are registers that change only
// when a conversion completes.
module score_bcd_converter #(
  parameter int unsigned BIN_W  = 17,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  ovf
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] max_display();
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display();
  // After reset the display shows a single "0": digit 0 is 0 and the rest are blanked.
  localparam logic [SW-1:0] RESET_DIGITS = {{(SW-4){1'b1}}, 4'h0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [BIN_W-1:0]  shreg, shreg_next;
  logic [SW-1:0]     scratch, scratch_next;
  logic [CW-1:0]     cnt;
  logic              ovf_pend;
  logic              last_shift;
  logic [SW-1:0]     disp;

  assign last_shift = (state == SHIFT) && (cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and Moore outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
  always_comb begin
    logic [SW-1:0] adj;
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    scratch_next = {adj[SW-2:0], shreg[BIN_W-1]};
    shreg_next   = shreg << 1;
  end

  // Display formatting of the final step's result: blank leading zeros, saturate on overflow.
  // It is computed from scratch_next so that digits update on the same edge that enters DONE.
  always_comb begin
    logic leading;
    int unsigned k;
    disp    = scratch_next;
    leading = 1'b1;
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      k = DIGITS - 1 - j;
      if (leading && (disp[4*k +: 4] == 4'h0)) disp[4*k +: 4] = 4'hF;
      else                                     leading = 1'b0;
    end
    if (ovf_pend) disp = {DIGITS{4'h9}};
  end

  // Datapath: capture when start is accepted, shift during SHIFT, publish results on the last shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      digits   <= RESET_DIGITS;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            scratch  <= '0;
            cnt      <= CW'(BIN_W);
            ovf_pend <= (64'(bin) > MAX_VAL);
          end
        end
        SHIFT: begin
          shreg   <= shreg_next;
          scratch <= scratch_next;
          cnt     <= cnt - CW'(1);
          if (last_shift) begin
            digits <= disp;
            ovf    <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
